// File: rtl/ddr3_pkg.sv
// Shared constants and helpers for the DDR3 read-return datapath.
package ddr3_pkg;

  // Beats per DDR3 BL8 burst on a 2:1 DFI interface.
  localparam int BURST_BEATS = 4;

  // A DFI beat carries two DQ samples (rising and falling edge).
  function automatic int beat_width(input int ddr3_width);
    return 2 * ddr3_width;
  endfunction

  // Classification of a read-data protocol violation seen on the DFI side.
  typedef enum logic [1:0] {
    ERR_NONE          = 2'd0,
    ERR_LAST_MISALIGN = 2'd1,
    ERR_ORPHAN_BEAT   = 2'd2
  } err_code_e;

endpackage

// File: rtl/ddr3_rd_path_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers. The head reads as zero while
// empty, so no stale entry ever reaches the outputs.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int ABITS = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int DEPTH = 1 << ABITS;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ABITS:0]   wptr;
  logic [ABITS:0]   rptr;

  assign empty = (wptr == rptr);
  assign rdata = empty ? '0 : mem[rptr[ABITS-1:0]];

  // Storage write.
  // NOTE: the array has no reset; validity comes from the pointers alone.
  always_ff @(posedge clock) begin
    if (push) mem[wptr[ABITS-1:0]] <= wdata;
  end

  // Pointer update; a pop on an empty FIFO is ignored.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push)          wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/ddr3_rd_path.sv
// DDR3 read-data return stage: reserves buffer space per burst, captures
// DFI beats without back-pressure, and replays them as a valid/ready stream.
module ddr3_rd_path
  import ddr3_pkg::*;
#(
  parameter int DDR3_WIDTH = 16,
  parameter int REQID      = 4,
  parameter int BURSTS     = 4
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               cmd_valid_i,
  output logic                               cmd_ready_o,
  input  logic [REQID-1:0]                   cmd_tid_i,
  input  logic                               dfi_rvld_i,
  input  logic                               dfi_last_i,
  input  logic [beat_width(DDR3_WIDTH)-1:0]  dfi_data_i,
  output logic                               rd_valid_o,
  input  logic                               rd_ready_i,
  output logic                               rd_last_o,
  output logic [REQID-1:0]                   rd_tid_o,
  output logic [beat_width(DDR3_WIDTH)-1:0]  rd_data_o,
  output logic                               err_o
);

  localparam int         BW        = beat_width(DDR3_WIDTH);
  localparam int         CW        = $clog2(BURSTS + 1);
  localparam logic [1:0] LAST_BEAT = 2'(BURST_BEATS - 1);

  logic [CW-1:0] credits;
  logic [CW-1:0] pending;
  logic [1:0]    icnt;
  logic [1:0]    ocnt;
  logic          err_q;
  logic          cmd_fire;
  logic          beat_ok;
  logic          burst_done;
  logic          rd_fire;
  logic          credit_ret;
  logic          data_empty;
  err_code_e     err_ev;

  assign cmd_ready_o = (credits != '0);
  assign cmd_fire    = cmd_valid_i & cmd_ready_o;
  assign beat_ok     = dfi_rvld_i & (pending != '0);
  assign burst_done  = beat_ok & (icnt == LAST_BEAT);
  assign rd_valid_o  = ~data_empty;
  assign rd_last_o   = rd_valid_o & (ocnt == LAST_BEAT);
  assign rd_fire     = rd_valid_o & rd_ready_i;
  assign credit_ret  = rd_fire & rd_last_o;
  assign err_o       = err_q;

  sync_fifo #(
    .WIDTH (BW),
    .ABITS ($clog2(BURST_BEATS * BURSTS))
  ) u_data_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (beat_ok),
    .wdata   (dfi_data_i),
    .pop     (rd_fire),
    .rdata   (rd_data_o),
    .empty   (data_empty)
  );

  sync_fifo #(
    .WIDTH (REQID),
    .ABITS ($clog2(BURSTS))
  ) u_tag_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (cmd_fire),
    .wdata   (cmd_tid_i),
    .pop     (credit_ret),
    .rdata   (rd_tid_o),
    .empty   ()
  );

  // Classify the incoming DFI beat against the expected burst framing.
  // NOTE: default assigned first so no path leaves err_ev unassigned (no latch).
  always_comb begin
    err_ev = ERR_NONE;
    if (dfi_rvld_i) begin
      if (pending == '0)                          err_ev = ERR_ORPHAN_BEAT;
      else if (dfi_last_i != (icnt == LAST_BEAT)) err_ev = ERR_LAST_MISALIGN;
    end
  end

  // Credits: taken by a reservation, returned when a burst's last beat leaves.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      credits <= CW'(BURSTS);
    end else begin
      case ({cmd_fire, credit_ret})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // Pending: bursts reserved whose four beats have not all arrived yet.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      case ({cmd_fire, burst_done})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
    end
  end

  // Input beat position; an early last resynchronises to the next burst.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      icnt <= '0;
    end else if (beat_ok) begin
      icnt <= (dfi_last_i && icnt != LAST_BEAT) ? 2'd0 : icnt + 2'd1;
    end
  end

  // Output beat position within the burst being returned.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     ocnt <= '0;
    else if (rd_fire) ocnt <= ocnt + 2'd1;
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                err_q <= 1'b0;
    else if (err_ev != ERR_NONE) err_q <= 1'b1;
  end

endmodule
